if_id_fetch_buffer: RTL and testbench

- Receiving end of the instruction-fetch interface: accepts (PC, instruction) pairs from the fetch stage and presents them to the decode stage.
- Built as a small circular FIFO with a valid/ready handshake on both sides, so decode stalls back-pressure fetch without losing instructions.
- Flushes on a taken branch (BranchTaken) so wrong-path instructions never reach decode.
- When empty, outputs a canonical NOP bubble.

---
 rtl/if_id_fetch_buffer.sv | 103 ++++++++++
 tb/tb_if_id_fetch_buffer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_buffer.sv
// IF/ID fetch buffer: circular FIFO of (PC, instruction) pairs between fetch and decode.
// Ports: clk, reset (async, active-high); in_valid/in_PC/in_instruction/in_ready from fetch;
// BranchTaken flushes all entries; out_valid/out_PC/out_instruction/out_ready to decode;
// count is the occupancy. An empty buffer presents a NOP bubble (out_PC=0).
// Define IFBUF_PERF_EN to add perf_stall_cycles, perf_flushed and perf_bubbles outputs.
module if_id_fetch_buffer #(
  parameter int          XLEN      = 64,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_PC,
  input  logic [31:0]              in_instruction,
  output logic                     in_ready,
  input  logic                     BranchTaken,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_PC,
  output logic [31:0]              out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFBUF_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flushed,
  output logic [31:0]              perf_bubbles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Ready/valid depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~BranchTaken;
  assign pop       = out_valid & out_ready & ~BranchTaken;

  assign out_PC          = out_valid ? pc_mem[rd_ptr]  : '0;
  assign out_instruction = out_valid ? ins_mem[rd_ptr] : NOP_INSTR;

  // Storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= in_PC;
      ins_mem[wr_ptr] <= in_instruction;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (BranchTaken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFBUF_PERF_EN
  logic [32:0] flush_sum;

  // Entries discarded by a flush: everything buffered plus the wrong-path input.
  always_comb begin
    flush_sum = {1'b0, perf_flushed} + 33'(count) + 33'(in_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushed      <= '0;
      perf_bubbles      <= '0;
    end else begin
      if (in_valid && !in_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (BranchTaken)
        perf_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
      if (!out_valid && out_ready && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Self-checking bench for if_id_fetch_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_if_id_fetch_buffer;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [XLEN-1:0] in_PC;
  logic [31:0]     in_instruction;
  logic            in_ready;
  logic            BranchTaken;
  logic            out_valid;
  logic [XLEN-1:0] out_PC;
  logic [31:0]     out_instruction;
  logic            out_ready;
  logic [CW-1:0]   count;
`ifdef IFBUF_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_flushed;
  logic [31:0]     perf_bubbles;
`endif

  if_id_fetch_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_PC(in_PC),
    .in_instruction(in_instruction),
    .in_ready(in_ready),
    .BranchTaken(BranchTaken),
    .out_valid(out_valid),
    .out_PC(out_PC),
    .out_instruction(out_instruction),
    .out_ready(out_ready),
    .count(count)
`ifdef IFBUF_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flushed(perf_flushed),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
  } ent_t;

  ent_t q[$];
  int   m_stall;
  int   m_flushed;
  int   m_bubbles;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [XLEN-1:0] exp_pc();
    return (q.size() != 0) ? q[0].pc : '0;
  endfunction

  function automatic logic [31:0] exp_ins();
    return (q.size() != 0) ? q[0].ins : NOP;
  endfunction

  // Reference model advances from the pre-edge inputs, then the clock edge is taken.
  task automatic tick();
    bit full  = (q.size() == DEPTH);
    bit empty = (q.size() == 0);
    if (in_valid && full) m_stall++;
    if (empty && out_ready) m_bubbles++;
    if (BranchTaken) begin
      m_flushed += q.size() + int'(in_valid);
      q.delete();
    end else begin
      if (!empty && out_ready) void'(q.pop_front());
      if (in_valid && !full) q.push_back('{in_PC, in_instruction});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_PC          = '0;
    in_instruction = '0;
    BranchTaken    = 1'b0;
    out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_stall = 0;
    m_flushed = 0;
    m_bubbles = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
               out_valid, in_ready, count);
    end
    n_checks++;
    if (out_PC !== '0 || out_instruction !== NOP) begin
      n_fail++;
      $display("FAIL reset_data: got pc=%h ins=%h want pc=0 ins=%h",
               out_PC, out_instruction, NOP);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_PC = 64'h0;
    in_instruction = 32'h00500093;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_PC !== 64'h0 || out_instruction !== 32'h00500093) begin
      n_fail++;
      $display("FAIL single_out: got v=%b pc=%h ins=%h want v=1 pc=0 ins=00500093",
               out_valid, out_PC, out_instruction);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_instruction !== NOP) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b ins=%h want v=0 ins=%h",
               out_valid, out_instruction, NOP);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_PC = 64'(4 * i);
      in_instruction = 32'h1000 + 32'(i);
      tick();
    end
    n_checks++;
    if (count !== CW'(2) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d r=%b want cnt=2 r=0", count, in_ready);
    end
    in_PC = 64'h8;
    in_instruction = 32'h1002;
    tick();
    n_checks++;
    if (count !== CW'(2) || out_PC !== 64'h0) begin
      n_fail++;
      $display("FAIL bp_hold: got cnt=%0d pc=%h want cnt=2 pc=0", count, out_PC);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_PC !== 64'h4 || count !== CW'(1) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop0: got pc=%h cnt=%0d r=%b want pc=4 cnt=1 r=1",
               out_PC, count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_PC !== 64'h8 || out_instruction !== 32'h1002 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL bp_pop1: got pc=%h ins=%h cnt=%0d want pc=8 ins=1002 cnt=1",
               out_PC, out_instruction, count);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_PC = 64'h10;
    in_instruction = 32'h2010;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_PC = 64'h14 + 64'(4 * i);
      in_instruction = 32'h2014 + 32'(4 * i);
      tick();
      n_checks++;
      if (count !== CW'(1) || out_PC !== 64'h14 + 64'(4 * i) ||
          out_instruction !== 32'h2014 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got cnt=%0d pc=%h ins=%h want cnt=1 pc=%h",
                 i, count, out_PC, out_instruction, 64'h14 + 64'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_PC = 64'(4 * i);
      in_instruction = 32'h3000 + 32'(i);
      tick();
    end
    in_PC = 64'h8;
    in_instruction = 32'h3002;
    BranchTaken = 1'b1;
    tick();
    BranchTaken = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_instruction !== NOP) begin
      n_fail++;
      $display("FAIL flush_state: got cnt=%0d v=%b r=%b ins=%h want 0 0 1 %h",
               count, out_valid, in_ready, out_instruction, NOP);
    end
    in_valid = 1'b1;
    in_PC = 64'h20;
    in_instruction = 32'h3020;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_PC !== 64'h20 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL flush_refill: got pc=%h cnt=%0d want pc=20 cnt=1", out_PC, count);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_wrongpath: got v=%b pc=%h want v=0", out_valid, out_PC);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_PC = 64'h40 + 64'(4 * i);
      in_instruction = 32'h4000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_instruction !== NOP || in_ready !== 1'b1 ||
        count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b ins=%h r=%b cnt=%0d want 0 %h 1 0",
               out_valid, out_instruction, in_ready, count, NOP);
    end
    #2;
    reset = 1'b0;
    q.delete();
    m_stall = 0;
    m_flushed = 0;
    m_bubbles = 0;
    in_valid = 1'b1;
    in_PC = 64'h60;
    in_instruction = 32'h4060;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_PC !== 64'h60 || out_instruction !== 32'h4060) begin
      n_fail++;
      $display("FAIL async_refill: got v=%b pc=%h ins=%h want 1 60 4060",
               out_valid, out_PC, out_instruction);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      BranchTaken = ($urandom_range(0, 15) == 0);
      in_PC = {$urandom, $urandom};
      in_instruction = $urandom;
      tick();
      n_checks++;
      if (count !== CW'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != DEPTH) || out_PC !== exp_pc() ||
          out_instruction !== exp_ins()) begin
        n_fail++;
        $display("FAIL rand_%0d: got cnt=%0d v=%b r=%b pc=%h ins=%h want cnt=%0d pc=%h ins=%h",
                 i, count, out_valid, in_ready, out_PC, out_instruction,
                 q.size(), exp_pc(), exp_ins());
      end
`ifdef IFBUF_PERF_EN
      n_checks++;
      if (perf_stall_cycles !== 32'(m_stall) || perf_flushed !== 32'(m_flushed) ||
          perf_bubbles !== 32'(m_bubbles)) begin
        n_fail++;
        $display("FAIL rand_perf_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 perf_stall_cycles, perf_flushed, perf_bubbles,
                 m_stall, m_flushed, m_bubbles);
      end
`endif
    end
    idle_inputs();
  endtask

`ifdef IFBUF_PERF_EN
  task automatic test_perf();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_PC = 64'(4 * i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      in_PC = 64'h8;
      tick();
    end
    n_checks++;
    if (perf_stall_cycles !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d want 3", perf_stall_cycles);
    end
    BranchTaken = 1'b1;
    tick();
    BranchTaken = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (perf_flushed !== 32'd3 || perf_bubbles !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_flush: got fl=%0d bub=%0d want fl=3 bub=0",
               perf_flushed, perf_bubbles);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef IFBUF_PERF_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
